// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-atomic round-robin merge of N_SRC AXI-Stream sources gated by FIFO prog_full
module axis_pkt_arbiter #(
  parameter int N_SRC = 4,
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int LEN_W = 16,
  localparam int IDX_W = $clog2(N_SRC)
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_SRC-1:0]           s_axis_tvalid,
  output logic [N_SRC-1:0]           s_axis_tready,
  input  logic [N_SRC*DATA_W-1:0]    s_axis_tdata,
  input  logic [N_SRC*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [N_SRC-1:0]           s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [KEEP_W-1:0]          m_axis_tkeep,
  output logic                       m_axis_tlast,
  input  logic                       fifo_prog_full,
  output logic [N_SRC-1:0]           grant,
  output logic                       pkt_done,
  output logic [IDX_W-1:0]           pkt_src,
  output logic [LEN_W-1:0]           pkt_len
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d, last_q, last_d, src_q, src_d, pick;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic done_q, done_d, found, xfer, hs;
  // Data path is a pure mux of the owner; reset forces the handshake signals low immediately.
  assign xfer = state_q == XFER && !areset;
  assign m_axis_tvalid = xfer & s_axis_tvalid[gidx_q];
  assign s_axis_tready = xfer ? N_SRC'(m_axis_tready) << gidx_q : '0;
  assign grant = xfer ? N_SRC'(1) << gidx_q : '0;
  assign m_axis_tdata = s_axis_tdata[gidx_q*DATA_W +: DATA_W];
  assign m_axis_tkeep = s_axis_tkeep[gidx_q*KEEP_W +: KEEP_W];
  assign m_axis_tlast = s_axis_tlast[gidx_q];
  assign hs = m_axis_tvalid & m_axis_tready;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign pkt_done = done_q;
  assign pkt_src = src_q;
  assign pkt_len = len_q;
  // Round-robin pick starting after the last owner, then packet-level next-state and status.
  always_comb begin
    state_d = state_q;
    gidx_d = gidx_q;
    last_d = last_q;
    cnt_d = cnt_q;
    src_d = src_q;
    len_d = len_q;
    done_d = 1'b0;
    found = 1'b0;
    pick = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!found && s_axis_tvalid[(int'(last_q) + k) % N_SRC]) begin
        found = 1'b1;
        pick = IDX_W'((int'(last_q) + k) % N_SRC);
      end
    end
    if (state_q == IDLE) begin
      if (found && !fifo_prog_full) begin
        state_d = XFER;
        gidx_d = pick;
        cnt_d = '0;
      end
    end else if (hs) begin
      cnt_d = cnt_inc;
      if (m_axis_tlast) begin
        state_d = IDLE;
        last_d = gidx_q;
        done_d = 1'b1;
        src_d = gidx_q;
        len_d = cnt_inc;
      end
    end
  end
  // State and status registers; last owner resets to the top index so source 0 wins first.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      gidx_q <= '0;
      last_q <= IDX_W'(N_SRC - 1);
      cnt_q <= '0;
      done_q <= 1'b0;
      src_q <= '0;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q <= gidx_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      src_q <= src_d;
      len_q <= len_d;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed checks of arbitration order, backpressure, gating, reset and length saturation
module tb_axis_pkt_arbiter;
  localparam int N = 4;
  logic clk = 0;
  logic areset;
  logic [N-1:0] s_axis_tvalid, s_axis_tready, s_axis_tlast, grant;
  logic [N*32-1:0] s_axis_tdata;
  logic [N*4-1:0] s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, fifo_prog_full, pkt_done;
  logic [31:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep, pkt_len;
  logic [1:0] pkt_src;
  int n_vec = 0, n_err = 0, cyc = 0;
  int npkt[N], plen[N], beat[N], pcnt[N];
  logic [31:0] base[N];
  logic [N-1:0] hs;
  bit tog = 0;
  logic [31:0] od[$];
  logic [3:0] okp[$];
  bit ol[$];
  int oc[$], ds[$], dl[$];

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.N_SRC(N), .DATA_W(32), .LEN_W(4)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .fifo_prog_full(fifo_prog_full), .grant(grant),
    .pkt_done(pkt_done), .pkt_src(pkt_src), .pkt_len(pkt_len)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i] = npkt[i] > 0;
      s_axis_tdata[i*32 +: 32] = base[i] + 32'(pcnt[i]) * 32'h100 + 32'(beat[i]);
      s_axis_tkeep[i*4 +: 4] = 4'(i + 1);
      s_axis_tlast[i] = beat[i] == plen[i] - 1;
    end
  endtask

  task automatic load(input int i, input int n, input int l, input logic [31:0] b);
    npkt[i] = n;
    plen[i] = l;
    beat[i] = 0;
    pcnt[i] = 0;
    base[i] = b;
    drive();
  endtask

  task automatic clear_logs();
    od.delete(); okp.delete(); ol.delete(); oc.delete(); ds.delete(); dl.delete();
  endtask

  task automatic step();
    #1;
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      od.push_back(m_axis_tdata); okp.push_back(m_axis_tkeep); ol.push_back(m_axis_tlast); oc.push_back(cyc);
    end
    if (pkt_done) begin
      ds.push_back(int'(pkt_src)); dl.push_back(int'(pkt_len));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (beat[i] == plen[i] - 1) begin
          beat[i] = 0; pcnt[i]++; npkt[i]--;
        end else beat[i]++;
      end
    end
    m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    drive();
    @(negedge clk);
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((npkt[0] | npkt[1] | npkt[2] | npkt[3]) != 0 && n < budget) begin
      step();
      n++;
    end
    check("run_timeout", 64'(n >= budget), 0);
    step();
    step();
  endtask

  initial begin
    areset = 1; fifo_prog_full = 0; m_axis_tready = 1;
    for (int i = 0; i < N; i++) load(i, i == 0 ? 2 : 1, 3, 32'(i + 1) << 24);
    @(negedge clk);
    repeat (3) begin
      step();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tready", s_axis_tready, 0);
      check("rst_grant", grant, 0);
    end
    areset = 0;
    clear_logs();
    step();
    check("rst_first_grant", grant, 4'b0001);
    run(80);
    check("rr_beats", od.size(), 15);
    for (int p = 0; p < 5 && od.size() == 15; p++)
      for (int b = 0; b < 3; b++) begin
        check("rr_data", od[3*p+b], (32'(p % 4 + 1) << 24) + (p == 4 ? 32'h100 : 0) + 32'(b));
        check("rr_keep", okp[3*p+b], 4'(p % 4 + 1));
        check("rr_last", ol[3*p+b], b == 2);
        check("rr_gap", oc[3*p+b] - oc[0], 4*p + b);
      end
    check("rr_done_n", ds.size(), 5);
    for (int p = 0; p < 5 && ds.size() == 5; p++) begin
      check("rr_done_src", ds[p], p % 4);
      check("rr_done_len", dl[p], 3);
    end
    clear_logs();
    tog = 1;
    load(2, 1, 5, 32'hA0);
    run(40);
    tog = 0;
    m_axis_tready = 1;
    check("bp_beats", od.size(), 5);
    for (int b = 0; b < 5 && od.size() == 5; b++) begin
      check("bp_data", od[b], 32'hA0 + 32'(b));
      check("bp_last", ol[b], b == 4);
    end
    check("bp_done_n", ds.size(), 1);
    if (ds.size() == 1) begin
      check("bp_done_src", ds[0], 2);
      check("bp_done_len", dl[0], 5);
    end
    clear_logs();
    fifo_prog_full = 1;
    load(1, 1, 4, 32'hB0);
    repeat (10) begin
      step();
      check("pf_grant_blocked", grant, 0);
      check("pf_tready_blocked", s_axis_tready, 0);
    end
    fifo_prog_full = 0;
    step();
    check("pf_grant", grant, 4'b0010);
    step();
    fifo_prog_full = 1;
    run(40);
    fifo_prog_full = 0;
    check("pf_beats", od.size(), 4);
    check("pf_done_n", ds.size(), 1);
    if (ds.size() == 1) begin
      check("pf_done_src", ds[0], 1);
      check("pf_done_len", dl[0], 4);
    end
    clear_logs();
    load(3, 1, 8, 32'hC0);
    for (int n = 0; n < 20 && od.size() < 2; n++) step();
    check("mr_pre_beats", od.size(), 2);
    areset = 1;
    #1;
    check("mr_tvalid", m_axis_tvalid, 0);
    check("mr_tready", s_axis_tready, 0);
    load(0, 1, 1, 32'hD0);
    step();
    step();
    check("mr_no_done", ds.size(), 0);
    areset = 0;
    step();
    check("mr_grant", grant, 4'b0001);
    run(40);
    check("mr_beats", od.size(), 9);
    if (od.size() == 9) begin
      check("mr_data_src0", od[2], 32'hD0);
      check("mr_data_resume", od[3], 32'hC2);
      check("mr_data_end", od[8], 32'hC7);
    end
    check("mr_done_n", ds.size(), 2);
    if (ds.size() == 2) begin
      check("mr_done_src0", ds[0], 0);
      check("mr_done_len0", dl[0], 1);
      check("mr_done_src1", ds[1], 3);
      check("mr_done_len1", dl[1], 6);
    end
    clear_logs();
    load(1, 1, 20, 32'hE0);
    run(80);
    check("sat_beats", od.size(), 20);
    for (int b = 0; b < 20 && od.size() == 20; b++) begin
      check("sat_data", od[b], 32'hE0 + 32'(b));
      check("sat_last", ol[b], b == 19);
    end
    check("sat_done_n", ds.size(), 1);
    if (ds.size() == 1) begin
      check("sat_done_src", ds[0], 1);
      check("sat_done_len", dl[0], 15);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
